// File: rtl/commit_trace_if.sv
`default_nettype none
// ============================================================================
// Module      : commit_trace_if
// Description : Bundle of signals between the CPU commit stream, the commit
//               trace buffer and the downstream trace consumer.
//               master : driven by the CPU / consumer side (bench top).
//               slave  : seen by commit_trace_buffer.
//   Producer side : rf_we/rf_pc/rf_addr/rf_wdata  (WB-stage register write)
//                   dm_we/dm_pc/dm_addr/dm_wdata  (MEM-stage data store)
//   Consumer side : trace_ready in; trace_valid/kind/pc/addr/data out
//   Status        : level (AW+1 bits), overflow, drop_count (16 bits)
// Revision    : 1.0 - initial release
// ============================================================================
interface commit_trace_if #(
    parameter int AW = 4
);
    logic          rf_we;
    logic [31:0]   rf_pc;
    logic [4:0]    rf_addr;
    logic [31:0]   rf_wdata;
    logic          dm_we;
    logic [31:0]   dm_pc;
    logic [31:0]   dm_addr;
    logic [31:0]   dm_wdata;
    logic          trace_ready;
    logic          trace_valid;
    logic          trace_kind;
    logic [31:0]   trace_pc;
    logic [31:0]   trace_addr;
    logic [31:0]   trace_data;
    logic [AW:0]   level;
    logic          overflow;
    logic [15:0]   drop_count;

    modport master (
        output rf_we, rf_pc, rf_addr, rf_wdata,
        output dm_we, dm_pc, dm_addr, dm_wdata,
        output trace_ready,
        input  trace_valid, trace_kind, trace_pc, trace_addr, trace_data,
        input  level, overflow, drop_count
    );

    modport slave (
        input  rf_we, rf_pc, rf_addr, rf_wdata,
        input  dm_we, dm_pc, dm_addr, dm_wdata,
        input  trace_ready,
        output trace_valid, trace_kind, trace_pc, trace_addr, trace_data,
        output level, overflow, drop_count
    );
endinterface
`default_nettype wire

// File: rtl/commit_trace_buffer.sv
`default_nettype none
// ============================================================================
// Module      : commit_trace_buffer
// Description : Captures architectural commits of the pipelined CPU (register
//               file writes from WB, data memory writes from MEM) together
//               with their PC into a FIFO and drains them to a trace consumer
//               over a valid/ready handshake.
//               Up to two events per cycle; when both arrive the DM entry is
//               queued ahead of the RF entry. Events that do not fit are
//               dropped, counted (saturating) and flagged by a sticky bit.
// Ports       : clk   - single clock, all state on posedge
//               reset - asynchronous, active-low, clears all state
//               bus   - commit_trace_if.slave (producer, consumer, status)
// Parameters  : DEPTH - FIFO entries, power of two, >= 4
//               AW    - log2(DEPTH)
// Macro       : TRACE_SKIP_R0_EN - when defined, register writes to r0 are
//               ignored entirely (neither queued nor counted as drops).
// Revision    : 1.0 - initial release
// ============================================================================
module commit_trace_buffer #(
    parameter int DEPTH = 16,
    parameter int AW    = 4
) (
    input  wire logic          clk,
    input  wire logic          reset,
    commit_trace_if.slave      bus
);

    localparam logic [AW:0] c_DEPTH = (AW+1)'(DEPTH);
    localparam logic [AW:0] c_TWO   = (AW+1)'(2);

    // ------------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------------
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [AW:0]   r_level;
    logic          r_overflow;
    logic [15:0]   r_drop_count;

    // Storage is not reset: occupancy is tracked by r_level alone.
    logic          r_mem_kind [DEPTH];
    logic [31:0]   r_mem_pc   [DEPTH];
    logic [31:0]   r_mem_addr [DEPTH];
    logic [31:0]   r_mem_data [DEPTH];

    // ------------------------------------------------------------------------
    // Next-state computation
    // ------------------------------------------------------------------------
    logic          w_ev_dm;
    logic          w_ev_rf;
    logic          w_pop;
    logic [AW:0]   w_free;
    logic          w_acc_dm;
    logic          w_acc_rf;
    logic [1:0]    w_n_drop;
    logic [AW-1:0] w_rf_slot;
    logic [AW-1:0] w_wr_ptr_next;
    logic [AW:0]   w_level_next;
    logic [16:0]   w_drop_sum;
    logic [15:0]   w_drop_next;

    always_comb begin
        w_ev_dm = bus.dm_we;
`ifdef TRACE_SKIP_R0_EN
        // Writes to $zero carry no architectural effect; suppress them.
        w_ev_rf = bus.rf_we && (bus.rf_addr != 5'd0);
`else
        w_ev_rf = bus.rf_we;
`endif

        w_pop  = (r_level != '0) && bus.trace_ready;

        // A pop this cycle frees its slot for an incoming event. Since a pop
        // implies level >= 1, free never exceeds DEPTH.
        w_free = c_DEPTH - r_level + (AW+1)'(w_pop);

        // DM is ordered first, so it claims the first free slot; RF needs a
        // second slot whenever DM is also present.
        w_acc_dm = w_ev_dm && (w_free != '0);
        w_acc_rf = w_ev_rf && (w_ev_dm ? (w_free >= c_TWO) : (w_free != '0));

        w_n_drop = 2'(w_ev_dm && !w_acc_dm) + 2'(w_ev_rf && !w_acc_rf);

        w_rf_slot     = r_wr_ptr + AW'(w_acc_dm);
        w_wr_ptr_next = r_wr_ptr + AW'(w_acc_dm) + AW'(w_acc_rf);
        w_level_next  = r_level + (AW+1)'(w_acc_dm) + (AW+1)'(w_acc_rf)
                        - (AW+1)'(w_pop);

        w_drop_sum  = {1'b0, r_drop_count} + 17'(w_n_drop);
        w_drop_next = w_drop_sum[16] ? 16'hFFFF : w_drop_sum[15:0];
    end

    // ------------------------------------------------------------------------
    // Control registers
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_wr_ptr     <= '0;
            r_rd_ptr     <= '0;
            r_level      <= '0;
            r_overflow   <= 1'b0;
            r_drop_count <= 16'd0;
        end else begin
            r_wr_ptr <= w_wr_ptr_next;
            r_level  <= w_level_next;
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            if (w_n_drop != 2'd0) begin
                r_overflow   <= 1'b1;
                r_drop_count <= w_drop_next;
            end
        end
    end

    // ------------------------------------------------------------------------
    // Entry storage
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (w_acc_dm) begin
            r_mem_kind[r_wr_ptr] <= 1'b1;
            r_mem_pc  [r_wr_ptr] <= bus.dm_pc;
            r_mem_addr[r_wr_ptr] <= bus.dm_addr;
            r_mem_data[r_wr_ptr] <= bus.dm_wdata;
        end
        if (w_acc_rf) begin
            r_mem_kind[w_rf_slot] <= 1'b0;
            r_mem_pc  [w_rf_slot] <= bus.rf_pc;
            r_mem_addr[w_rf_slot] <= {27'd0, bus.rf_addr};
            r_mem_data[w_rf_slot] <= bus.rf_wdata;
        end
    end

    // ------------------------------------------------------------------------
    // Outputs: decoded from registered state only, never from the inputs.
    // The head fields read as zero while the FIFO is empty.
    // ------------------------------------------------------------------------
    logic w_valid;
    assign w_valid = (r_level != '0);

    assign bus.trace_valid = w_valid;
    assign bus.trace_kind  = w_valid ? r_mem_kind[r_rd_ptr] : 1'b0;
    assign bus.trace_pc    = w_valid ? r_mem_pc  [r_rd_ptr] : 32'd0;
    assign bus.trace_addr  = w_valid ? r_mem_addr[r_rd_ptr] : 32'd0;
    assign bus.trace_data  = w_valid ? r_mem_data[r_rd_ptr] : 32'd0;
    assign bus.level       = r_level;
    assign bus.overflow    = r_overflow;
    assign bus.drop_count  = r_drop_count;

endmodule
`default_nettype wire

// File: tb/tb_commit_trace_buffer.sv
`default_nettype none
// ============================================================================
// Module      : tb_commit_trace_buffer
// Description : Self-checking bench for commit_trace_buffer. Stimulus pushes
//               the entries it expects to emerge into a scoreboard queue; a
//               monitor pops and compares on every accepted head entry.
//               Status outputs are checked against hand-computed constants.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_commit_trace_buffer;

    localparam int DEPTH = 16;
    localparam int AW    = 4;

    logic clk   = 1'b0;
    logic reset = 1'b0;

    always #5 clk = ~clk;

    commit_trace_if #(.AW(AW)) bus ();

    commit_trace_buffer #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct packed {
        logic        kind;
        logic [31:0] pc;
        logic [31:0] addr;
        logic [31:0] data;
    } ent_t;

    ent_t sb[$];
    int   checks   = 0;
    int   failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%08h required=0x%08h", name, act, exp);
        end
    endtask

    // Monitor: compares every entry accepted by the consumer.
    always @(negedge clk) begin : mon
        ent_t e;
        if (reset && bus.trace_valid && bus.trace_ready) begin
            checks++;
            if (sb.size() == 0) begin
                failures++;
                $display("FAIL unexpected_entry actual pc=0x%08h required=none", bus.trace_pc);
            end else begin
                e = sb.pop_front();
                if ({bus.trace_kind, bus.trace_pc, bus.trace_addr, bus.trace_data} !== e) begin
                    failures++;
                    $display("FAIL drain_entry actual kind=%0d pc=0x%08h addr=0x%08h data=0x%08h required kind=%0d pc=0x%08h addr=0x%08h data=0x%08h",
                             bus.trace_kind, bus.trace_pc, bus.trace_addr, bus.trace_data,
                             e.kind, e.pc, e.addr, e.data);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clr();
        bus.rf_we = 1'b0;
        bus.dm_we = 1'b0;
    endtask

    task automatic rf_ev(input logic [31:0] pc, input logic [4:0] a,
                         input logic [31:0] d, input bit expect_q);
        bus.rf_we    = 1'b1;
        bus.rf_pc    = pc;
        bus.rf_addr  = a;
        bus.rf_wdata = d;
        if (expect_q) sb.push_back({1'b0, pc, {27'd0, a}, d});
    endtask

    task automatic dm_ev(input logic [31:0] pc, input logic [31:0] a,
                         input logic [31:0] d, input bit expect_q);
        bus.dm_we    = 1'b1;
        bus.dm_pc    = pc;
        bus.dm_addr  = a;
        bus.dm_wdata = d;
        if (expect_q) sb.push_back({1'b1, pc, a, d});
    endtask

    task automatic drain(input string name);
        bus.trace_ready = 1'b1;
        for (int k = 0; k < 40 && bus.level != '0; k++) tick();
        bus.trace_ready = 1'b0;
        chk({name, "_level"}, 32'(bus.level), 32'd0);
        chk({name, "_sb_empty"}, 32'(sb.size()), 32'd0);
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        bit skip_r0;
`ifdef TRACE_SKIP_R0_EN
        skip_r0 = 1'b1;
`else
        skip_r0 = 1'b0;
`endif
        bus.trace_ready = 1'b0;
        bus.rf_pc = '0; bus.rf_addr = '0; bus.rf_wdata = '0;
        bus.dm_pc = '0; bus.dm_addr = '0; bus.dm_wdata = '0;
        clr();

        // Reset state
        repeat (2) tick();
        chk("rst_valid", 32'(bus.trace_valid), 32'd0);
        chk("rst_level", 32'(bus.level), 32'd0);
        chk("rst_overflow", 32'(bus.overflow), 32'd0);
        chk("rst_drop", 32'(bus.drop_count), 32'd0);
        chk("rst_pc", bus.trace_pc, 32'd0);
        @(negedge clk);
        reset = 1'b1;
        tick();

        // Mid-stream asynchronous reset with five entries held
        for (int i = 0; i < 5; i++) begin
            rf_ev(32'h1000 + 32'(4*i), 5'(i+1), 32'(i), 1'b0);
            tick();
        end
        clr();
        chk("t1_level5", 32'(bus.level), 32'd5);
        #2 reset = 1'b0;
        #1;
        chk("t1_async_valid", 32'(bus.trace_valid), 32'd0);
        chk("t1_async_level", 32'(bus.level), 32'd0);
        chk("t1_async_overflow", 32'(bus.overflow), 32'd0);
        chk("t1_async_drop", 32'(bus.drop_count), 32'd0);
        @(negedge clk);
        reset = 1'b1;
        tick();

        // Single RF write with the consumer ready
        bus.trace_ready = 1'b1;
        rf_ev(32'h3000, 5'd5, 32'h1234, 1'b1);
        tick();
        clr();
        chk("t2_valid", 32'(bus.trace_valid), 32'd1);
        chk("t2_kind", 32'(bus.trace_kind), 32'd0);
        chk("t2_pc", bus.trace_pc, 32'h3000);
        chk("t2_addr", bus.trace_addr, 32'h5);
        chk("t2_data", bus.trace_data, 32'h1234);
        tick();
        chk("t2_level_after", 32'(bus.level), 32'd0);
        chk("t2_valid_after", 32'(bus.trace_valid), 32'd0);
        chk("t2_data_zero", bus.trace_data, 32'd0);

        // DM and RF in the same cycle, consumer stalled
        bus.trace_ready = 1'b0;
        dm_ev(32'h3008, 32'h10, 32'hAA, 1'b1);
        rf_ev(32'h3004, 5'd8, 32'h55, 1'b1);
        tick();
        clr();
        chk("t3_level", 32'(bus.level), 32'd2);
        chk("t3_kind", 32'(bus.trace_kind), 32'd1);
        chk("t3_addr", bus.trace_addr, 32'h10);
        tick();
        chk("t3_stall_pc", bus.trace_pc, 32'h3008);
        bus.trace_ready = 1'b1;
        tick();
        bus.trace_ready = 1'b0;
        chk("t3_level1", 32'(bus.level), 32'd1);
        chk("t3_kind2", 32'(bus.trace_kind), 32'd0);
        chk("t3_addr2", bus.trace_addr, 32'h8);
        chk("t3_data2", bus.trace_data, 32'h55);
        drain("t3_drain");

        // Fill to DEPTH, push+pop at full, then overflow
        for (int i = 0; i < 16; i++) begin
            rf_ev(32'h4000 + 32'(4*i), 5'(i+1), 32'h100 + 32'(i), 1'b1);
            tick();
        end
        clr();
        chk("t4_full_level", 32'(bus.level), 32'd16);
        chk("t4_full_overflow", 32'(bus.overflow), 32'd0);
        bus.trace_ready = 1'b1;
        rf_ev(32'h5000, 5'd31, 32'hBEEF, 1'b1);
        tick();
        clr();
        bus.trace_ready = 1'b0;
        chk("t5_level", 32'(bus.level), 32'd16);
        chk("t5_overflow", 32'(bus.overflow), 32'd0);
        chk("t5_drop", 32'(bus.drop_count), 32'd0);
        rf_ev(32'h6000, 5'd3, 32'hDEAD, 1'b0);
        tick();
        clr();
        chk("t4_ovf_level", 32'(bus.level), 32'd16);
        chk("t4_ovf_flag", 32'(bus.overflow), 32'd1);
        chk("t4_ovf_drop", 32'(bus.drop_count), 32'd1);
        drain("t4_drain");

        // Two events at DEPTH-1: DM accepted, RF dropped
        for (int i = 0; i < 15; i++) begin
            rf_ev(32'h7000 + 32'(4*i), 5'(i+2), 32'h200 + 32'(i), 1'b1);
            tick();
        end
        clr();
        chk("t7_level15", 32'(bus.level), 32'd15);
        dm_ev(32'h8000, 32'h40, 32'h77, 1'b1);
        rf_ev(32'h8004, 5'd9, 32'h99, 1'b0);
        tick();
        clr();
        chk("t7_level16", 32'(bus.level), 32'd16);
        chk("t7_drop", 32'(bus.drop_count), 32'd2);
        chk("t7_overflow", 32'(bus.overflow), 32'd1);
        chk("t7_head_pc", bus.trace_pc, 32'h7000);
        drain("t7_drain");

        // Write to r0
        rf_ev(32'h9000, 5'd0, 32'h5A5A, !skip_r0);
        tick();
        clr();
        if (skip_r0) begin
            chk("t6_r0_level", 32'(bus.level), 32'd0);
        end else begin
            chk("t6_r0_level", 32'(bus.level), 32'd1);
            chk("t6_r0_addr", bus.trace_addr, 32'd0);
        end
        drain("t6_drain");

        // Sticky status clears only on reset
        chk("t8_overflow_held", 32'(bus.overflow), 32'd1);
        #2 reset = 1'b0;
        #1;
        chk("t8_rst_overflow", 32'(bus.overflow), 32'd0);
        chk("t8_rst_drop", 32'(bus.drop_count), 32'd0);
        @(negedge clk);
        reset = 1'b1;
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
